genius_round_engine: RTL and testbench

Parametrised game-sequence engine for the GENIUS (Simon) game. It replaces the fixed 4-LED counter/mux datapath with one FSM-driven block. Each round it appends a pseudo-random step to an internal sequence memory and plays the sequence on the LEDs. It then checks the user's key strobes against the stored sequence under a per-key timeout, and accumulates points. It sits between the debounced KEY/SWITCH front end and the hex-display muxes, and drives `round`, `points` and the status flags those muxes select on.

---
 rtl/genius_round_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_genius_round_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/genius_round_engine.sv
// GENIUS (Simon) round engine: builds a random sequence, plays it on the LEDs and checks the user's keys.
// Optional `GENIUS_SPEEDUP_EN` shortens the show time as the sequence grows.
module genius_round_engine #(
  parameter int          P_LED     = 4,
  parameter int          P_DEPTH   = 16,
  parameter int          P_SHOW    = 25_000_000,
  parameter int          P_TIMEOUT = 250_000_000,
  parameter logic [15:0] P_SEED    = 16'hACE1
) (
  input  logic                         CLOCK_50,
  input  logic                         R,
  input  logic                         start,
  input  logic [$clog2(P_DEPTH+1)-1:0] setup,
  input  logic [P_LED-1:0]             key_i,
  output logic [P_LED-1:0]             leds,
  output logic [$clog2(P_DEPTH+1)-1:0] round,
  output logic [7:0]                   points,
  output logic                         end_FPGA,
  output logic                         end_User,
  output logic                         end_time,
  output logic                         lose,
  output logic                         win,
  output logic                         match,
  output logic                         busy
);
  localparam int RW   = $clog2(P_DEPTH + 1);
  localparam int LW   = (P_LED > 1) ? $clog2(P_LED) : 1;
  localparam int IW   = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int TMAX = (P_SHOW > P_TIMEOUT) ? P_SHOW : P_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_USER, S_WIN, S_LOSE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_lfsr;
  logic [LW-1:0] r_mem [P_DEPTH];
  logic [RW-1:0] r_round, r_target, r_idx;
  logic [RW-1:0] w_round_nxt, w_target_nxt, w_idx_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [P_LED-1:0] r_leds, w_leds_nxt;
  logic [7:0]    r_points, w_points_nxt;
  logic r_end_fpga, r_end_user, r_end_time, r_lose, r_win, r_match, r_busy;
  logic w_end_fpga_nxt, w_end_user_nxt, w_end_time_nxt, w_lose_nxt;
  logic w_win_nxt, w_match_nxt, w_busy_nxt;

  logic [LW-1:0]    w_step, w_first;
  logic [RW-1:0]    w_idx_inc, w_setup_clamp;
  logic             w_last;
  logic [P_LED-1:0] w_expect;
  logic [8:0]       w_psum;
  logic [31:0]      w_show_len, w_gap_len;
  logic [TW-1:0]    w_on_last, w_off_last;

  function automatic logic [P_LED-1:0] f_onehot(input logic [LW-1:0] s);
    f_onehot    = '0;
    f_onehot[s] = 1'b1;
  endfunction

`ifdef GENIUS_SPEEDUP_EN
  always_comb begin
    w_show_len = 32'(P_SHOW);
    if (32'(r_round) >= 32'd8)      w_show_len = 32'(P_SHOW) >> 2;
    else if (32'(r_round) >= 32'd4) w_show_len = 32'(P_SHOW) >> 1;
    if (w_show_len == 32'd0)        w_show_len = 32'd1;
  end
`else
  assign w_show_len = 32'(P_SHOW);
`endif

  assign w_gap_len  = (w_show_len > 32'd1) ? (w_show_len >> 1) : 32'd1;
  assign w_on_last  = TW'(w_show_len - 32'd1);
  assign w_off_last = TW'(w_gap_len - 32'd1);

  assign w_step    = r_lfsr[LW-1:0];
  // In the very first GEN the step is being written this cycle, so bypass the memory.
  assign w_first   = (r_round == '0) ? w_step : r_mem[0];
  assign w_idx_inc = r_idx + 1'b1;
  assign w_last    = (r_idx == r_round - 1'b1);
  assign w_expect  = f_onehot(r_mem[r_idx[IW-1:0]]);
  assign w_psum    = {1'b0, r_points} + 9'(r_round);

  always_comb begin
    w_setup_clamp = setup;
    if (setup == '0)               w_setup_clamp = RW'(1);
    else if (setup > RW'(P_DEPTH)) w_setup_clamp = RW'(P_DEPTH);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_round_nxt    = r_round;
    w_target_nxt   = r_target;
    w_idx_nxt      = r_idx;
    w_timer_nxt    = r_timer;
    w_leds_nxt     = r_leds;
    w_points_nxt   = r_points;
    w_end_fpga_nxt = 1'b0;
    w_end_user_nxt = 1'b0;
    w_match_nxt    = 1'b0;
    w_end_time_nxt = r_end_time;
    w_lose_nxt     = r_lose;
    w_win_nxt      = r_win;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          w_target_nxt   = w_setup_clamp;
          w_round_nxt    = '0;
          w_points_nxt   = '0;
          w_win_nxt      = 1'b0;
          w_lose_nxt     = 1'b0;
          w_end_time_nxt = 1'b0;
          w_state_nxt    = S_GEN;
        end
      end
      S_GEN: begin
        w_round_nxt = r_round + 1'b1;
        w_idx_nxt   = '0;
        w_timer_nxt = '0;
        w_leds_nxt  = f_onehot(w_first);
        w_state_nxt = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (r_timer == w_on_last) begin
          w_timer_nxt = '0;
          w_leds_nxt  = '0;
          w_state_nxt = S_SHOW_OFF;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_SHOW_OFF: begin
        if (r_timer == w_off_last) begin
          w_timer_nxt = '0;
          if (!w_last) begin
            w_idx_nxt   = w_idx_inc;
            w_leds_nxt  = f_onehot(r_mem[w_idx_inc[IW-1:0]]);
            w_state_nxt = S_SHOW_ON;
          end else begin
            w_end_fpga_nxt = 1'b1;
            w_idx_nxt      = '0;
            w_state_nxt    = S_WAIT_USER;
          end
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_WAIT_USER: begin
        // A correct key on the timeout cycle wins over the timeout.
        if (key_i == '0) begin
          if (r_timer == TW'(P_TIMEOUT - 1)) begin
            w_end_time_nxt = 1'b1;
            w_state_nxt    = S_LOSE;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end else if (key_i == w_expect) begin
          w_match_nxt = 1'b1;
          w_timer_nxt = '0;
          if (w_last) begin
            w_end_user_nxt = 1'b1;
            w_points_nxt   = w_psum[8] ? 8'hFF : w_psum[7:0];
            if (r_round == r_target) begin
              w_win_nxt   = 1'b1;
              w_state_nxt = S_WIN;
            end else begin
              w_state_nxt = S_GEN;
            end
          end else begin
            w_idx_nxt = w_idx_inc;
          end
        end else begin
          w_lose_nxt  = 1'b1;
          w_state_nxt = S_LOSE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = !(w_state_nxt inside {S_IDLE, S_WIN, S_LOSE});
  end

  always_ff @(posedge CLOCK_50 or posedge R) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_lfsr     <= P_SEED;
      r_round    <= '0;
      r_target   <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_leds     <= '0;
      r_points   <= '0;
      r_end_fpga <= 1'b0;
      r_end_user <= 1'b0;
      r_end_time <= 1'b0;
      r_lose     <= 1'b0;
      r_win      <= 1'b0;
      r_match    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_round    <= w_round_nxt;
      r_target   <= w_target_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      r_leds     <= w_leds_nxt;
      r_points   <= w_points_nxt;
      r_end_fpga <= w_end_fpga_nxt;
      r_end_user <= w_end_user_nxt;
      r_end_time <= w_end_time_nxt;
      r_lose     <= w_lose_nxt;
      r_win      <= w_win_nxt;
      r_match    <= w_match_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (r_state == S_GEN) r_mem[r_round[IW-1:0]] <= w_step;
  end

  assign leds     = r_leds;
  assign round    = r_round;
  assign points   = r_points;
  assign end_FPGA = r_end_fpga;
  assign end_User = r_end_user;
  assign end_time = r_end_time;
  assign lose     = r_lose;
  assign win      = r_win;
  assign match    = r_match;
  assign busy     = r_busy;
endmodule

// File: tb/tb_genius_round_engine.sv
// Directed bench for genius_round_engine: table of whole games plus hand-written timing corner cases.
module tb_genius_round_engine;
  localparam int LED = 4, DEPTH = 8, SHOW = 4, TOUT = 20;
  localparam int RW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] setup = '0;
  logic [3:0]    key_i = '0;
  logic [3:0]    leds;
  logic [RW-1:0] round;
  logic [7:0]    points;
  logic end_FPGA, end_User, end_time, lose, win, match, busy;

  genius_round_engine #(
    .P_LED(LED), .P_DEPTH(DEPTH), .P_SHOW(SHOW), .P_TIMEOUT(TOUT), .P_SEED(16'hACE1)
  ) dut (
    .CLOCK_50(clk), .R(R), .start(start), .setup(setup), .key_i(key_i),
    .leds(leds), .round(round), .points(points), .end_FPGA(end_FPGA),
    .end_User(end_User), .end_time(end_time), .lose(lose), .win(win),
    .match(match), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_endf = 0, n_endu = 0;
  logic [3:0] seq  [DEPTH];
  logic [3:0] play [DEPTH];
  int play_n;

  always @(negedge clk) begin
    if (end_FPGA) n_endf++;
    if (end_User) n_endu++;
  end

  typedef struct {
    int setup; int bad_round; int bad_kind; int noise;
    int exp_round; int exp_points; int exp_win; int exp_lose; int exp_endf; int exp_endu;
  } vec_t;
  vec_t tbl [5];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_playback(input int r, input bit noise);
    logic [3:0] prev;
    bit done;
    prev = '0; play_n = 0; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (leds != '0 && prev == '0) begin
        if (play_n < DEPTH) play[play_n] = leds;
        play_n++;
      end
      prev = leds;
      if (end_FPGA) done = 1'b1;
      else begin
        key_i = (noise && leds != '0) ? 4'b1111 : 4'b0000;
        tick();
      end
    end
    key_i = '0;
    chk("playback_done", int'(done), 1);
    chk("playback_len", play_n, r);
    for (int i = 0; i < r && i < DEPTH; i++) begin
      chk("step_onehot", $countones(play[i]), 1);
      if (i < r - 1) chk("replay_step", int'(play[i]), int'(seq[i]));
      seq[i] = play[i];
    end
  endtask

  task automatic answer(input int n, input bit final_round);
    for (int i = 0; i < n; i++) begin
      key_i = seq[i];
      tick();
      key_i = '0;
      chk("key_match", int'(match), 1);
      chk("end_user", int'(end_User), (i == n - 1) ? 1 : 0);
    end
    if (!final_round) begin
      tick();
      chk("next_round_step", int'(leds != '0), 1);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t;
    int f0, u0, n;
    //        setup bad kind noise round pts win lose endf endu
    tbl[0] = '{3,    0,  0,   1,    3,    6,  1,  0,   3,   3};
    tbl[1] = '{3,    2,  1,   0,    2,    1,  0,  1,   2,   1};
    tbl[2] = '{0,    0,  0,   0,    1,    1,  1,  0,   1,   1};
    tbl[3] = '{12,   0,  0,   0,    8,   36,  1,  0,   8,   8};
    tbl[4] = '{2,    1,  2,   0,    1,    0,  0,  1,   1,   0};

    // reset defaults
    repeat (3) tick();
    R = 1'b0;
    repeat (10) tick();
    chk("rst_leds", int'(leds), 0);
    chk("rst_round", int'(round), 0);
    chk("rst_points", int'(points), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_end_fpga", int'(end_FPGA), 0);
    chk("rst_end_user", int'(end_User), 0);
    chk("rst_end_time", int'(end_time), 0);
    chk("rst_lose", int'(lose), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_match", int'(match), 0);

    for (int k = 0; k < 5; k++) begin
      t = tbl[k];
      f0 = n_endf; u0 = n_endu;
      setup = RW'(t.setup); start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_points", int'(points), 0);
      chk("start_round", int'(round), 0);
      chk("start_win", int'(win), 0);
      chk("start_lose", int'(lose), 0);
      chk("start_busy", int'(busy), 1);
      for (int r = 1; r <= t.exp_round; r++) begin
        wait_playback(r, t.noise != 0);
        if (r == t.bad_round) begin
          key_i = (t.bad_kind == 2) ? 4'b0011 : {seq[0][2:0], seq[0][3]};
          tick();
          key_i = '0;
          chk("bad_no_match", int'(match), 0);
          break;
        end
        answer(r, r == t.exp_round);
      end
      tick(); tick();
      chk("game_win", int'(win), t.exp_win);
      chk("game_lose", int'(lose), t.exp_lose);
      chk("game_end_time", int'(end_time), 0);
      chk("game_points", int'(points), t.exp_points);
      chk("game_round", int'(round), t.exp_round);
      chk("game_busy", int'(busy), 0);
      chk("game_end_fpga_cnt", n_endf - f0, t.exp_endf);
      chk("game_end_user_cnt", n_endu - u0, t.exp_endu);
    end

    // timeout: end_time exactly TOUT cycles after end_FPGA
    setup = RW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    wait_playback(1, 1'b0);
    n = 0;
    while (!end_time && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TOUT);
    chk("timeout_flag", int'(end_time), 1);
    chk("timeout_lose", int'(lose), 0);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_win", int'(win), 0);

    // correct key on the timeout cycle beats the timeout
    setup = RW'(2); start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_end_time", int'(end_time), 0);
    wait_playback(1, 1'b0);
    repeat (TOUT - 1) tick();
    key_i = seq[0];
    tick();
    key_i = '0;
    chk("edge_key_match", int'(match), 1);
    chk("edge_key_end_time", int'(end_time), 0);
    chk("edge_key_end_user", int'(end_User), 1);
    tick();
    chk("edge_next_round", int'(leds != '0), 1);
    wait_playback(2, 1'b0);
    answer(2, 1'b1);
    tick(); tick();
    chk("edge_win", int'(win), 1);
    chk("edge_points", int'(points), 3);
    chk("edge_end_time", int'(end_time), 0);

    // reset in the middle of SHOW_ON, then restart timing
    setup = RW'(3); start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (leds == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("show_seen", int'(leds != '0), 1);
    #2;
    R = 1'b1;
    #1;
    chk("async_rst_leds", int'(leds), 0);
    chk("async_rst_round", int'(round), 0);
    chk("async_rst_busy", int'(busy), 0);
    tick();
    R = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("gen_leds_dark", int'(leds), 0);
    chk("gen_busy", int'(busy), 1);
    tick();
    chk("first_step_onehot", $countones(leds), 1);
    chk("first_round", int'(round), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
